// File: rtl/ladder_pkg.sv
// Shared types for the ladder step generator.
package ladder_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  typedef enum logic {MODE_TRI = 1'b0, MODE_SAW = 1'b1} mode_e;

endpackage

// File: rtl/ladder_cfg_shadow.sv
// One-deep shadow for new ladder bounds: accepts on valid&&ready, rejects
// empty/inverted ranges with a one-cycle err pulse, released by consume.
module ladder_cfg_shadow
  import ladder_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         valid,
  input  logic [W-1:0] lo_in,
  input  logic [W-1:0] hi_in,
  input  mode_e        mode_in,
  input  logic         consume,
  output logic         ready,
  output logic         full,
  output logic         err,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output mode_e        mode
);

  logic take;
  logic bounds_ok;

  assign take      = valid && !full;
  assign bounds_ok = hi_in > lo_in;
  assign ready     = !full;

  // take and consume are mutually exclusive: consume needs full, take needs !full
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      full <= 1'b0;
      err  <= 1'b0;
      lo   <= '0;
      hi   <= '0;
      mode <= MODE_TRI;
    end else begin
      err <= take && !bounds_ok;
      if (take && bounds_ok) begin
        full <= 1'b1;
        lo   <= lo_in;
        hi   <= hi_in;
        mode <= mode_in;
      end else if (consume) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ladder_gen.sv
// Programmable triangle/sawtooth ladder generator with shadowed bounds.
// Defining LADDER_STATS_EN adds the completed-period counter on `periods`.
// state | meaning
// IDLE  | no bounds applied yet, waiting for a first config
// RUN   | stepping current between the active lo/hi
module ladder_gen
  import ladder_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          en,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [W-1:0]  cfg_lo,
  input  logic [W-1:0]  cfg_hi,
  input  logic          cfg_mode,
  output logic          cfg_err,
  output logic [W-1:0]  current,
  output logic [CW-1:0] count,
  output logic          direction,
  output logic          peak,
  output logic          trough,
  output logic [CW-1:0] periods
);

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    mode_e        mode;
  } cfg_t;

  state_e        state, state_n;
  cfg_t          act, act_n, sh;
  logic [W-1:0]  sh_lo, sh_hi, cur_n;
  mode_e         sh_mode;
  logic [CW-1:0] cnt_n;
  logic          dir_n, sh_full, consume, boundary;

  ladder_cfg_shadow #(.W(W)) u_shadow (
    .clk     (clk),
    .resetn  (resetn),
    .valid   (cfg_valid),
    .lo_in   (cfg_lo),
    .hi_in   (cfg_hi),
    .mode_in (mode_e'(cfg_mode)),
    .consume (consume),
    .ready   (cfg_ready),
    .full    (sh_full),
    .err     (cfg_err),
    .lo      (sh_lo),
    .hi      (sh_hi),
    .mode    (sh_mode)
  );

  assign sh = '{lo: sh_lo, hi: sh_hi, mode: sh_mode};

  // Period boundary: sawtooth wrap point or triangle trough turnaround.
  assign boundary = (state == RUN) &&
                    ((act.mode == MODE_SAW) ? (current >= act.hi)
                                            : (!direction && current <= act.lo));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      act       <= '0;
      current   <= '0;
      count     <= '0;
      direction <= 1'b1;
    end else begin
      state     <= state_n;
      act       <= act_n;
      current   <= cur_n;
      count     <= cnt_n;
      direction <= dir_n;
    end
  end

  always_comb begin
    state_n = state;
    act_n   = act;
    cur_n   = current;
    cnt_n   = count;
    dir_n   = direction;
    consume = 1'b0;
    if (en) begin
      if (state == IDLE) begin
        if (sh_full) begin
          act_n   = sh;
          cur_n   = sh.lo;
          dir_n   = 1'b1;
          consume = 1'b1;
          state_n = RUN;
        end
      end else if (boundary) begin
        cnt_n = count + 1'b1;
        dir_n = 1'b1;
        if (sh_full) begin
          act_n   = sh;
          cur_n   = sh.lo;
          consume = 1'b1;
        end else if (act.mode == MODE_SAW) begin
          cur_n = act.lo;
        end else begin
          cur_n = act.lo + 1'b1;
        end
      end else if (act.mode == MODE_SAW || direction) begin
        if (current < act.hi) begin
          cur_n = current + 1'b1;
          cnt_n = count + 1'b1;
        end else begin
          cur_n = act.hi - 1'b1;
          cnt_n = count - 1'b1;
          dir_n = 1'b0;
        end
      end else begin
        cur_n = current - 1'b1;
        cnt_n = count - 1'b1;
      end
    end
  end

  assign peak   = (state == RUN) && (current == act.hi);
  assign trough = (state == RUN) && (current == act.lo);

`ifdef LADDER_STATS_EN
  logic [CW-1:0] periods_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      periods_q <= '0;
    end else if (en && boundary) begin
      periods_q <= periods_q + 1'b1;
    end
  end

  assign periods = periods_q;
`else
  assign periods = '0;
`endif

endmodule

// File: tb/tb_ladder_gen.sv
// Table-driven bench for ladder_gen (W=4, CW=8) with hand-written reset checks.
module tb_ladder_gen;

`ifdef LADDER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn, en, cfg_valid, cfg_mode;
  logic [3:0] cfg_lo, cfg_hi;
  logic       cfg_ready, cfg_err, direction, peak, trough;
  logic [3:0] current;
  logic [7:0] count, periods;

  int checks = 0;
  int failures = 0;

  ladder_gen #(.W(4), .CW(8)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_lo    (cfg_lo),
    .cfg_hi    (cfg_hi),
    .cfg_mode  (cfg_mode),
    .cfg_err   (cfg_err),
    .current   (current),
    .count     (count),
    .direction (direction),
    .peak      (peak),
    .trough    (trough),
    .periods   (periods)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en, v;
    logic [3:0] lo, hi;
    logic       md;
    logic [3:0] cur;
    logic [7:0] cnt;
    logic       dir, pk, tr, rdy, err;
    logic [7:0] per;
  } vec_t;

  localparam int NV = 37;
  localparam int SPLIT = 18;
  vec_t tv[NV];

  function automatic vec_t mk(input int e, v, lo, hi, md, cur, cnt, dir, pk, tr, rdy, err, per);
    vec_t r;
    r.en = e[0]; r.v = v[0]; r.lo = lo[3:0]; r.hi = hi[3:0]; r.md = md[0];
    r.cur = cur[3:0]; r.cnt = cnt[7:0]; r.dir = dir[0]; r.pk = pk[0];
    r.tr = tr[0]; r.rdy = rdy[0]; r.err = err[0]; r.per = per[7:0];
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0h expected=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    en        = tv[i].en;
    cfg_valid = tv[i].v;
    cfg_lo    = tv[i].lo;
    cfg_hi    = tv[i].hi;
    cfg_mode  = tv[i].md;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    chk("current",   i, 16'(current),   16'(tv[i].cur));
    chk("count",     i, 16'(count),     16'(tv[i].cnt));
    chk("direction", i, 16'(direction), 16'(tv[i].dir));
    chk("peak",      i, 16'(peak),      16'(tv[i].pk));
    chk("trough",    i, 16'(trough),    16'(tv[i].tr));
    chk("cfg_ready", i, 16'(cfg_ready), 16'(tv[i].rdy));
    chk("cfg_err",   i, 16'(cfg_err),   16'(tv[i].err));
    chk("periods",   i, 16'(periods),   STATS ? 16'(tv[i].per) : 16'd0);
  endtask

  task automatic chk_reset_state(input int tag);
    chk("rst_current",   tag, 16'(current),   16'd0);
    chk("rst_count",     tag, 16'(count),     16'd0);
    chk("rst_direction", tag, 16'(direction), 16'd1);
    chk("rst_cfg_ready", tag, 16'(cfg_ready), 16'd1);
    chk("rst_cfg_err",   tag, 16'(cfg_err),   16'd0);
    chk("rst_peak",      tag, 16'(peak),      16'd0);
    chk("rst_trough",    tag, 16'(trough),    16'd0);
    chk("rst_periods",   tag, 16'(periods),   16'd0);
  endtask

  initial begin
    //           en v lo hi md | cur cnt dir pk tr rdy err per
    tv[0]  = mk(1, 1, 5, 5, 0,  0,  0, 1, 0, 0, 1, 1, 0); // lo==hi rejected from IDLE
    tv[1]  = mk(1, 0, 0, 0, 0,  0,  0, 1, 0, 0, 1, 0, 0);
    tv[2]  = mk(1, 1, 1, 3, 0,  0,  0, 1, 0, 0, 0, 0, 0); // accepted, still IDLE
    tv[3]  = mk(1, 0, 0, 0, 0,  1,  0, 1, 0, 1, 1, 0, 0);
    tv[4]  = mk(1, 0, 0, 0, 0,  2,  1, 1, 0, 0, 1, 0, 0);
    tv[5]  = mk(1, 0, 0, 0, 0,  3,  2, 1, 1, 0, 1, 0, 0);
    tv[6]  = mk(1, 0, 0, 0, 0,  2,  1, 0, 0, 0, 1, 0, 0);
    tv[7]  = mk(1, 0, 0, 0, 0,  1,  0, 0, 0, 1, 1, 0, 0);
    tv[8]  = mk(1, 0, 0, 0, 0,  2,  1, 1, 0, 0, 1, 0, 1);
    tv[9]  = mk(1, 0, 0, 0, 0,  3,  2, 1, 1, 0, 1, 0, 1);
    tv[10] = mk(0, 0, 0, 0, 0,  3,  2, 1, 1, 0, 1, 0, 1); // en low at top
    tv[11] = mk(0, 0, 0, 0, 0,  3,  2, 1, 1, 0, 1, 0, 1);
    tv[12] = mk(0, 0, 0, 0, 0,  3,  2, 1, 1, 0, 1, 0, 1);
    tv[13] = mk(1, 0, 0, 0, 0,  2,  1, 0, 0, 0, 1, 0, 1);
    tv[14] = mk(1, 1, 2, 5, 0,  1,  0, 0, 0, 1, 0, 0, 1); // offer mid-descent
    tv[15] = mk(1, 0, 0, 0, 0,  2,  1, 1, 0, 1, 1, 0, 2); // applied at trough
    tv[16] = mk(1, 1, 0, 2, 1,  3,  2, 1, 0, 0, 0, 0, 2);
    tv[17] = mk(1, 0, 0, 0, 0,  4,  3, 1, 0, 0, 0, 0, 2);
    tv[18] = mk(1, 0, 0, 0, 0,  0,  0, 1, 0, 0, 1, 0, 0); // after reset: no restart
    tv[19] = mk(1, 0, 0, 0, 0,  0,  0, 1, 0, 0, 1, 0, 0);
    tv[20] = mk(1, 1, 0, 2, 1,  0,  0, 1, 0, 0, 0, 0, 0);
    tv[21] = mk(1, 0, 0, 0, 0,  0,  0, 1, 0, 1, 1, 0, 0);
    tv[22] = mk(1, 0, 0, 0, 0,  1,  1, 1, 0, 0, 1, 0, 0);
    tv[23] = mk(1, 0, 0, 0, 0,  2,  2, 1, 1, 0, 1, 0, 0);
    tv[24] = mk(1, 0, 0, 0, 0,  0,  3, 1, 0, 1, 1, 0, 1);
    tv[25] = mk(1, 0, 0, 0, 0,  1,  4, 1, 0, 0, 1, 0, 1);
    tv[26] = mk(1, 0, 0, 0, 0,  2,  5, 1, 1, 0, 1, 0, 1);
    tv[27] = mk(1, 0, 0, 0, 0,  0,  6, 1, 0, 1, 1, 0, 2);
    tv[28] = mk(1, 1, 6, 7, 0,  1,  7, 1, 0, 0, 0, 0, 2); // saw -> tri hi=lo+1
    tv[29] = mk(1, 0, 0, 0, 0,  2,  8, 1, 1, 0, 0, 0, 2);
    tv[30] = mk(1, 0, 0, 0, 0,  6,  9, 1, 0, 1, 1, 0, 3);
    tv[31] = mk(1, 0, 0, 0, 0,  7, 10, 1, 1, 0, 1, 0, 3);
    tv[32] = mk(1, 0, 0, 0, 0,  6,  9, 0, 0, 1, 1, 0, 3);
    tv[33] = mk(1, 0, 0, 0, 0,  7, 10, 1, 1, 0, 1, 0, 4);
    tv[34] = mk(1, 0, 0, 0, 0,  6,  9, 0, 0, 1, 1, 0, 4);
    tv[35] = mk(1, 1, 7, 3, 0,  7, 10, 1, 1, 0, 1, 1, 5); // inverted range while running
    tv[36] = mk(1, 0, 0, 0, 0,  6,  9, 0, 0, 1, 1, 0, 5);

    resetn = 1'b0; en = 1'b0; cfg_valid = 1'b0;
    cfg_lo = '0; cfg_hi = '0; cfg_mode = 1'b0;
    #12;
    chk_reset_state(-1);
    resetn = 1'b1;

    for (int i = 0; i < SPLIT; i++) run_vec(i);

    // Async reset mid-run with the shadow full and current=4.
    #3;
    resetn = 1'b0;
    #1;
    chk_reset_state(-2);
    #2;
    resetn = 1'b1;

    for (int i = SPLIT; i < NV; i++) run_vec(i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
